// File: rtl/decode_stage_pipe.sv
// RV32I decode stage: field split, immediate build, register file
// with write-back bypass, branch resolve, registered execute bundle.
module decode_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter bit BYPASS   = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_wb_en,
  input  logic [4:0]      i_wb_rd_num,
  input  logic [XLEN-1:0] i_wb_val,
  input  logic            i_ex_load,
  input  logic [4:0]      i_ex_rd_num,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_rs_1,
  output logic [XLEN-1:0] o_rs_2,
  output logic [XLEN-1:0] o_imm,
  output logic [4:0]      o_rd_num,
  output logic [6:0]      o_opcode,
  output logic [2:0]      o_func_3,
  output logic [6:0]      o_func_7,
  output logic            o_b_taken,
  output logic [XLEN-1:0] o_b_pc
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRAN  = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  logic [XLEN-1:0] r_regs [1:NUM_REGS-1];

  logic [6:0]      w_op;
  logic [4:0]      w_rd;
  logic [2:0]      w_f3;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [6:0]      w_f7;
  logic            w_wr_ok;
  logic [XLEN-1:0] w_rf_1;
  logic [XLEN-1:0] w_rf_2;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [XLEN-1:0] w_imm;
  logic            w_use1;
  logic            w_use2;
  logic            w_hazard;
  logic            w_accept;
  logic            w_take;
  logic [XLEN-1:0] w_pc_imm;
  logic [XLEN-1:0] w_rs_imm;
  logic [XLEN-1:0] w_tgt;

  assign w_op  = i_inst[6:0];
  assign w_rd  = i_inst[11:7];
  assign w_f3  = i_inst[14:12];
  assign w_rs1 = i_inst[19:15];
  assign w_rs2 = i_inst[24:20];
  assign w_f7  = i_inst[31:25];

  assign w_wr_ok = i_wb_en && (i_wb_rd_num != 5'd0)
                && ({1'b0, i_wb_rd_num} < 6'(NUM_REGS));

  // Register file read; out-of-range numbers and x0 read zero
  always_comb begin
    w_rf_1 = '0;
    w_rf_2 = '0;
    for (int k = 1; k < NUM_REGS; k++) begin
      if (w_rs1 == 5'(k)) w_rf_1 = r_regs[k];
      if (w_rs2 == 5'(k)) w_rf_2 = r_regs[k];
    end
  end

  assign w_rs1_val = (BYPASS && w_wr_ok && (i_wb_rd_num == w_rs1))
                   ? i_wb_val : w_rf_1;
  assign w_rs2_val = (BYPASS && w_wr_ok && (i_wb_rd_num == w_rs2))
                   ? i_wb_val : w_rf_2;

  // Register file write-back, independent of flush and stall
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int k = 1; k < NUM_REGS; k++) r_regs[k] <= '0;
    end else if (w_wr_ok) begin
      for (int k = 1; k < NUM_REGS; k++)
        if (i_wb_rd_num == 5'(k)) r_regs[k] <= i_wb_val;
    end
  end

  // Immediate selection by opcode
  always_comb begin
    w_imm = '0;
    unique case (w_op)
      OP_LOAD, OP_IMM, OP_JALR:
        w_imm = XLEN'($signed(i_inst[31:20]));
      OP_STORE:
        w_imm = XLEN'($signed({i_inst[31:25], i_inst[11:7]}));
      OP_BRAN:
        w_imm = XLEN'($signed({i_inst[31], i_inst[7],
                               i_inst[30:25], i_inst[11:8], 1'b0}));
      OP_LUI, OP_AUIPC:
        w_imm = XLEN'($signed({i_inst[31:12], 12'b0}));
      OP_JAL:
        w_imm = XLEN'($signed({i_inst[31], i_inst[19:12],
                               i_inst[20], i_inst[30:21], 1'b0}));
      default: w_imm = '0;
    endcase
  end

  assign w_use1 = !((w_op == OP_LUI) || (w_op == OP_AUIPC)
                 || (w_op == OP_JAL));
  assign w_use2 = (w_op == OP_REG) || (w_op == OP_STORE)
               || (w_op == OP_BRAN);

  assign w_hazard = i_valid && i_ex_load && (i_ex_rd_num != 5'd0)
                 && ((w_use1 && (i_ex_rd_num == w_rs1))
                  || (w_use2 && (i_ex_rd_num == w_rs2)));

  assign o_ready  = i_rst && (!o_valid || i_ready)
                 && !w_hazard && !i_flush;
  assign w_accept = i_valid && o_ready;

  assign w_pc_imm = i_pc + w_imm;
  assign w_rs_imm = w_rs1_val + w_imm;

  // Branch and jump resolution on the bypassed operands
  always_comb begin
    w_take = 1'b0;
    w_tgt  = w_pc_imm;
    unique case (w_op)
      OP_JAL: w_take = 1'b1;
      OP_JALR: begin
        w_take = 1'b1;
        w_tgt  = {w_rs_imm[XLEN-1:1], 1'b0};
      end
      OP_BRAN: begin
        case (w_f3)
          3'b000:  w_take = (w_rs1_val == w_rs2_val);
          3'b001:  w_take = (w_rs1_val != w_rs2_val);
          3'b100:  w_take = ($signed(w_rs1_val) < $signed(w_rs2_val));
          3'b101:  w_take = ($signed(w_rs1_val) >= $signed(w_rs2_val));
          3'b110:  w_take = (w_rs1_val < w_rs2_val);
          3'b111:  w_take = (w_rs1_val >= w_rs2_val);
          default: w_take = 1'b0;
        endcase
      end
      default: w_take = 1'b0;
    endcase
  end

  assign o_b_taken = w_accept && w_take;
  assign o_b_pc    = o_b_taken ? w_tgt : '0;

  // Execute-bound output slot with valid/ready handshake
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_valid  <= 1'b0;
      o_pc     <= '0;
      o_rs_1   <= '0;
      o_rs_2   <= '0;
      o_imm    <= '0;
      o_rd_num <= '0;
      o_opcode <= '0;
      o_func_3 <= '0;
      o_func_7 <= '0;
    end else if (w_accept) begin
      o_valid  <= 1'b1;
      o_pc     <= i_pc;
      o_rs_1   <= w_rs1_val;
      o_rs_2   <= w_rs2_val;
      o_imm    <= w_imm;
      o_rd_num <= w_rd;
      o_opcode <= w_op;
      o_func_3 <= w_f3;
      o_func_7 <= w_f7;
    end else if (i_ready || i_flush) begin
      o_valid  <= 1'b0;
    end
  end

endmodule
